// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } memState_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // $0 is hardwired, so a producer writing it never feeds a consumer.
  function automatic logic regHit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts qualifying cycles, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                  count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage MIPS pipeline, with a
// bounded data-memory wait and saturating performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_err
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  logic memReq, mwait, lwStall, brStall;
  memState_e state, stateNxt;
  logic [WC_W-1:0] waitCnt, waitCntNxt;
  logic setErr;

  assign memReq  = MemtoRegM | MemWriteM;
  assign mwait   = memReq & ~mem_ready;
  assign lwStall = MemtoRegE & (regHit(RtE, RsD) | regHit(RtE, RtD));
  assign brStall = BranchD &
                   ((RegWriteE & (regHit(WriteRegE, RsD) | regHit(WriteRegE, RtD))) |
                    (MemtoRegM & (regHit(WriteRegM, RsD) | regHit(WriteRegM, RtD))));

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!clr_n) begin
      // Bubbles everywhere while held in reset.
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (RegWriteM && regHit(WriteRegM, RsE))      ForwardAE = FWD_MEM;
      else if (RegWriteW && regHit(WriteRegW, RsE)) ForwardAE = FWD_WB;
      if (RegWriteM && regHit(WriteRegM, RtE))      ForwardBE = FWD_MEM;
      else if (RegWriteW && regHit(WriteRegW, RtE)) ForwardBE = FWD_WB;
      ForwardAD = RegWriteM & regHit(WriteRegM, RsD);
      ForwardBD = RegWriteM & regHit(WriteRegM, RtD);

      // A taken branch under mwait is dropped here; D is held, so it recurs.
      if (mwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (lwStall | brStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSrcD | JumpD) begin
        FlushD = 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    setErr     = 1'b0;
    case (state)
      RUN: if (mwait) begin
        stateNxt   = MWAIT;
        waitCntNxt = WC_W'(1);
      end
      MWAIT: begin
        if (mem_ready) begin
          stateNxt   = RUN;
          waitCntNxt = '0;
        end else if (waitCnt == WC_LAST) begin
          setErr     = 1'b1;
          stateNxt   = RUN;
          waitCntNxt = '0;
        end else begin
          waitCntNxt = waitCnt + WC_W'(1);
        end
      end
      default: begin
        stateNxt   = RUN;
        waitCntNxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= RUN;
      waitCnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
      if (setErr) mem_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (StallF),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (FlushD | FlushE),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expectations queued by the
// scenario tasks and compared on the falling edge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic clr_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic BranchD, PCSrcD, JumpD, mem_ready;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .clr_n(clr_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_err(mem_err)
  );

  typedef struct {
    logic [3:0] st;   // {F,D,E,M}
    logic [2:0] fl;   // {D,E,W}
    logic [5:0] fwd;  // {AE,BE,AD,BD}
    logic       merr;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];
  int    errors = 0;
  int    checks = 0;
  logic [CNT_W-1:0] scM = '0, feM = '0;
  logic  expErr = 1'b0;

  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0; mem_ready = 0;
  endtask

  function automatic void pushExp(string nm, logic [3:0] st, logic [2:0] fl,
                                  logic [1:0] ae, logic [1:0] be, logic ad, logic bd);
    exp_t e;
    e.st = st; e.fl = fl; e.fwd = {ae, be, ad, bd}; e.merr = expErr;
    sbq.push_back(e);
    nmq.push_back(nm);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops one expectation per cycle; counters modelled from expectations.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (!clr_n) begin
      scM = '0;
      feM = '0;
    end else if (sbq.size() != 0) begin
      e  = sbq.pop_front();
      nm = nmq.pop_front();
      checks++;
      if ({StallF, StallD, StallE, StallM} !== e.st) begin
        errors++;
        $display("FAIL %s stall got=%b exp=%b", nm, {StallF, StallD, StallE, StallM}, e.st);
      end
      checks++;
      if ({FlushD, FlushE, FlushW} !== e.fl) begin
        errors++;
        $display("FAIL %s flush got=%b exp=%b", nm, {FlushD, FlushE, FlushW}, e.fl);
      end
      checks++;
      if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== e.fwd) begin
        errors++;
        $display("FAIL %s fwd got=%b exp=%b", nm,
                 {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, e.fwd);
      end
      checks++;
      if (mem_err !== e.merr) begin
        errors++;
        $display("FAIL %s mem_err got=%b exp=%b", nm, mem_err, e.merr);
      end
      checks++;
      if (stall_cycles !== scM) begin
        errors++;
        $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stall_cycles, scM);
      end
      checks++;
      if (flush_events !== feM) begin
        errors++;
        $display("FAIL %s flush_events got=%0d exp=%0d", nm, flush_events, feM);
      end
      if (e.st[3] && scM != '1) scM = scM + 1'b1;
      if ((e.fl[2] | e.fl[1]) && feM != '1) feM = feM + 1'b1;
    end
  end

  task automatic test_reset();
    idle();
    clr_n = 1'b0;
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 3; RsE = 3; RsD = 3; PCSrcD = 1;
    #2;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000111) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=0000111",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    checks++;
    if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'b0) begin
      errors++;
      $display("FAIL reset_fwd got=%b exp=000000", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
    end
    repeat (2) step();
    checks++;
    if ({stall_cycles, flush_events, mem_err} !== '0 || dut.state !== RUN) begin
      errors++;
      $display("FAIL reset_state got sc=%0d fe=%0d err=%b st=%0d exp 0 0 0 0",
               stall_cycles, flush_events, mem_err, dut.state);
    end
    idle();
    clr_n = 1'b1;
  endtask

  task automatic test_lw_stall();
    idle(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2; RtD = 5;
    pushExp("lw_stall", 4'b1100, 3'b010, FWD_RF, FWD_RF, 0, 0); step();
    idle(); RegWriteM = 1; MemtoRegM = 1; WriteRegM = 2; mem_ready = 1; RsD = 2; RtD = 5;
    pushExp("lw_bubble", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1, 0); step();
    idle(); RegWriteW = 1; WriteRegW = 2; RsE = 2; RtE = 5;
    pushExp("lw_fwd_wb", 4'b0000, 3'b000, FWD_WB, FWD_RF, 0, 0); step();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL lw_stall_count got=%0d exp=1", stall_cycles);
    end
  endtask

  task automatic test_forwarding();
    idle(); RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3;
    RsE = 3; RtE = 3; RsD = 3; RtD = 7;
    pushExp("fwd_m_wins", 4'b0, 3'b0, FWD_MEM, FWD_MEM, 1, 0); step();
    idle(); RegWriteW = 1; WriteRegW = 4; RtE = 4; WriteRegM = 3; RsE = 3; RtD = 3;
    pushExp("fwd_wb", 4'b0, 3'b0, FWD_RF, FWD_WB, 0, 0); step();
    idle(); RegWriteM = 1; RegWriteW = 1;
    pushExp("fwd_r0", 4'b0, 3'b0, FWD_RF, FWD_RF, 0, 0); step();
  endtask

  task automatic test_branch();
    idle(); BranchD = 1; PCSrcD = 1; RsD = 1; RtD = 2;
    pushExp("br_taken", 4'b0, 3'b100, FWD_RF, FWD_RF, 0, 0); step();
    idle();
    pushExp("br_after", 4'b0, 3'b000, FWD_RF, FWD_RF, 0, 0); step();
    idle(); BranchD = 1; PCSrcD = 1; RsD = 1; RtD = 2; RegWriteE = 1; WriteRegE = 1;
    pushExp("br_stall_e", 4'b1100, 3'b010, FWD_RF, FWD_RF, 0, 0); step();
    idle(); BranchD = 1; RsD = 6; RtD = 1; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 1;
    mem_ready = 1;
    pushExp("br_stall_m", 4'b1100, 3'b010, FWD_RF, FWD_RF, 0, 1); step();
    idle(); JumpD = 1;
    pushExp("jump", 4'b0, 3'b100, FWD_RF, FWD_RF, 0, 0); step();
  endtask

  task automatic test_mem_wait();
    idle(); MemtoRegM = 1; RegWriteM = 1; WriteRegM = 4;
    BranchD = 1; PCSrcD = 1; RsD = 1; RtD = 2;
    for (int i = 0; i < 5; i++) begin
      pushExp("mwait", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 0); step();
      if (i == 0) begin
        checks++;
        if (dut.state !== MWAIT) begin
          errors++;
          $display("FAIL mwait_state got=%0d exp=%0d", dut.state, MWAIT);
        end
      end
    end
    mem_ready = 1;
    pushExp("mready", 4'b0000, 3'b100, FWD_RF, FWD_RF, 0, 0); step();
    checks++;
    if (dut.state !== RUN || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL mready_state got st=%0d err=%b exp st=0 err=0", dut.state, mem_err);
    end
    idle();
    pushExp("mw_idle", 4'b0, 3'b0, FWD_RF, FWD_RF, 0, 0); step();
  endtask

  task automatic test_timeout();
    idle(); MemWriteM = 1;
    for (int k = 1; k <= 10; k++) begin
      if (k == TMO + 1) expErr = 1'b1;
      pushExp("timeout", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 0); step();
    end
    checks++;
    if (dut.state !== MWAIT) begin
      errors++;
      $display("FAIL timeout_rewait got=%0d exp=%0d", dut.state, MWAIT);
    end
    clr_n = 1'b0;
    expErr = 1'b0;
    #1;
    checks++;
    if (dut.state !== RUN || stall_cycles !== '0 || flush_events !== '0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset got st=%0d sc=%0d fe=%0d err=%b exp 0 0 0 0",
               dut.state, stall_cycles, flush_events, mem_err);
    end
    checks++;
    if ({StallF, FlushD, FlushE, FlushW} !== 4'b0111) begin
      errors++;
      $display("FAIL midwait_reset_ctl got=%b exp=0111", {StallF, FlushD, FlushE, FlushW});
    end
    step();
    idle();
    clr_n = 1'b1;
  endtask

  task automatic test_saturate();
    idle(); MemtoRegE = 1; RtE = 9; RsD = 9;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      pushExp("sat", 4'b1100, 3'b010, FWD_RF, FWD_RF, 0, 0); step();
    end
    checks++;
    if (stall_cycles !== 4'd15 || flush_events !== 4'd15) begin
      errors++;
      $display("FAIL saturate got sc=%0d fe=%0d exp=15 15", stall_cycles, flush_events);
    end
    idle();
    pushExp("sat_hold", 4'b0, 3'b0, FWD_RF, FWD_RF, 0, 0); step();
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_forwarding();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
